// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : RV32I instruction encoder. Accepts decoded field bundles,
//               packs them into 32-bit instruction words, tags each word
//               with its IMEM byte address and buffers {instr, addr} in a
//               2-entry output FIFO. Tracks sticky opcode/range errors.
//               Optional immediate range checking: ENC_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        load_start,
    input  logic [31:0] load_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_opcode,
    output logic        err_range,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam logic [6:0]  c_op_r      = 7'b0110011;
    localparam logic [6:0]  c_op_imm    = 7'b0010011;
    localparam logic [6:0]  c_op_load   = 7'b0000011;
    localparam logic [6:0]  c_op_jalr   = 7'b1100111;
    localparam logic [6:0]  c_op_store  = 7'b0100011;
    localparam logic [6:0]  c_op_branch = 7'b1100011;
    localparam logic [6:0]  c_op_jal    = 7'b1101111;
    localparam logic [6:0]  c_op_lui    = 7'b0110111;
    localparam logic [6:0]  c_op_auipc  = 7'b0010111;
    localparam logic [31:0] c_nop       = 32'h0000_0013;

    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_addr_q,  head_addr_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_addr_q,  tail_addr_d;
    logic [1:0]  count_q,      count_d;
    logic [31:0] cnt_q,        cnt_d;
    logic        err_opcode_q, err_opcode_d;
    logic        err_range_q,  err_range_d;
    logic [31:0] err_addr_q,   err_addr_d;

    logic [31:0] w_enc_word;
    logic        w_opc_bad;
    logic        w_rng_bad;
    logic        w_is_shift;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_wr_slot;
    logic [31:0] w_acc_addr;
    logic        w_new_opc;
    logic        w_new_rng;

    assign w_is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);

    // Pack the field bundle into an instruction word by format.
    always_comb begin
        w_enc_word = c_nop;
        w_opc_bad  = 1'b0;
        case (in_opcode)
            c_op_r:
                w_enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
            c_op_imm: begin
                if (w_is_shift)
                    w_enc_word = {in_func7, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode};
                else
                    w_enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
            end
            c_op_load, c_op_jalr:
                w_enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
            c_op_store:
                w_enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
            c_op_branch:
                w_enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                              in_imm[4:1], in_imm[11], in_opcode};
            c_op_jal:
                w_enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            c_op_lui, c_op_auipc:
                w_enc_word = {in_imm[31:12], in_rd, in_opcode};
            default:
                w_opc_bad = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Flag immediates whose dropped bits would change the encoded value.
    always_comb begin
        w_rng_bad = 1'b0;
        case (in_opcode)
            c_op_imm: begin
                if (w_is_shift)
                    w_rng_bad = |in_imm[31:5];
                else
                    w_rng_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            c_op_load, c_op_jalr, c_op_store:
                w_rng_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            c_op_branch:
                w_rng_bad = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
            c_op_jal:
                w_rng_bad = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
            c_op_lui, c_op_auipc:
                w_rng_bad = |in_imm[11:0];
            default:
                w_rng_bad = 1'b0;
        endcase
    end
`else
    assign w_rng_bad = 1'b0;
`endif

    assign in_ready  = (count_q < 2'd2);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // Slot the incoming word lands in once any simultaneous pop has shifted.
    assign w_wr_slot = count_q - {1'b0, w_pop};
    // A load coinciding with an accept hands load_base to that bundle.
    assign w_acc_addr = load_start ? load_base : cnt_q;
    assign w_new_opc  = w_push && w_opc_bad;
    assign w_new_rng  = w_push && w_rng_bad;

    // Next-state for FIFO, address counter and sticky error tracking.
    always_comb begin
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        count_d      = count_q + {1'b0, w_push} - {1'b0, w_pop};
        cnt_d        = cnt_q;
        err_opcode_d = err_opcode_q;
        err_range_d  = err_range_q;
        err_addr_d   = err_addr_q;

        if (w_pop) begin
            head_instr_d = tail_instr_q;
            head_addr_d  = tail_addr_q;
        end
        if (w_push) begin
            if (w_wr_slot == 2'd0) begin
                head_instr_d = w_enc_word;
                head_addr_d  = w_acc_addr;
            end else begin
                tail_instr_d = w_enc_word;
                tail_addr_d  = w_acc_addr;
            end
            cnt_d = w_acc_addr + 32'd4;
        end else if (load_start) begin
            cnt_d = load_base;
        end

        // Capture is decided against the pre-clear flags; a clear in the
        // same cycle as a new error re-arms the capture.
        if ((w_new_opc || w_new_rng) &&
            (err_clr || (!err_opcode_q && !err_range_q)))
            err_addr_d = w_acc_addr;
        if (err_clr) begin
            err_opcode_d = 1'b0;
            err_range_d  = 1'b0;
        end
        if (w_new_opc)
            err_opcode_d = 1'b1;
        if (w_new_rng)
            err_range_d = 1'b1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr_q <= 32'd0;
            head_addr_q  <= 32'd0;
            tail_instr_q <= 32'd0;
            tail_addr_q  <= 32'd0;
            count_q      <= 2'd0;
            cnt_q        <= 32'd0;
            err_opcode_q <= 1'b0;
            err_range_q  <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            err_opcode_q <= err_opcode_d;
            err_range_q  <= err_range_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = head_instr_q;
    assign out_addr   = head_addr_q;
    assign err_opcode = err_opcode_q;
    assign err_range  = err_range_q;
    assign err_addr   = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. Directed scenarios
//               plus randomized traffic against a queue-based reference
//               model. Honours ENC_RANGE_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        load_start;
    logic [31:0] load_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr, out_addr;
    logic        err_opcode, err_range;
    logic [31:0] err_addr;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_cnt;
    bit          m_eo, m_er;
    logic [31:0] m_ea;

    localparam logic [6:0] c_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                        7'b1100111, 7'b0100011, 7'b1100011,
                                        7'b1101111, 7'b0110111, 7'b0010111};

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_func3   (in_func3),
        .in_func7   (in_func7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .load_start (load_start),
        .load_base  (load_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_opcode (err_opcode),
        .err_range  (err_range),
        .err_addr   (err_addr),
        .err_clr    (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Encoding straight from the format table; range by signed magnitude.
    function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm,
                                            output bit opc_bad, output bit rng_bad);
        longint s;
        logic [31:0] w;
        s = longint'($signed(imm));
        opc_bad = 0;
        rng_bad = 0;
        w = 32'h13;
        case (op)
            7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
            7'b0010011: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                    rng_bad = (imm > 32'd31);
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                    rng_bad = (s < -2048 || s > 2047);
                end
            end
            7'b0000011, 7'b1100111: begin
                w = {imm[11:0], rs1, f3, rd, op};
                rng_bad = (s < -2048 || s > 2047);
            end
            7'b0100011: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                rng_bad = (s < -2048 || s > 2047);
            end
            7'b1100011: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                rng_bad = (s < -4096 || s > 4095 || (s % 2) != 0);
            end
            7'b1101111: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                rng_bad = (s < -1048576 || s > 1048575 || (s % 2) != 0);
            end
            7'b0110111, 7'b0010111: begin
                w = {imm[31:12], rd, op};
                rng_bad = (imm % 32'd4096) != 0;
            end
            default: opc_bad = 1;
        endcase
`ifndef ENC_RANGE_CHECK_EN
        rng_bad = 0;
`endif
        return w;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_cnt = 32'd0;
        m_eo  = 0;
        m_er  = 0;
        m_ea  = 32'd0;
    endtask

    task automatic set_idle();
        in_valid   = 0;
        in_opcode  = '0;
        in_func3   = '0;
        in_func7   = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        load_start = 0;
        load_base  = '0;
        err_clr    = 0;
    endtask

    task automatic set_bundle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        in_valid  = 1;
        in_opcode = op;
        in_func3  = f3;
        in_func7  = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // Compare DUT to model, advance the model for the coming edge, clock once.
    task automatic cycle(input string tag);
        bit ob, rb, push, pop, new_o, new_r, cap;
        logic [31:0] w, a;
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
        check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check_eq({tag, ".out_instr"}, out_instr, mq[0][63:32]);
            check_eq({tag, ".out_addr"}, out_addr, mq[0][31:0]);
        end
        check_eq({tag, ".err_opcode"}, {31'd0, err_opcode}, {31'd0, m_eo});
        check_eq({tag, ".err_range"}, {31'd0, err_range}, {31'd0, m_er});
        check_eq({tag, ".err_addr"}, err_addr, m_ea);

        push = in_valid && (mq.size() < 2);
        pop  = (mq.size() != 0) && out_ready;
        a    = load_start ? load_base : m_cnt;
        w    = ref_enc(in_opcode, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, ob, rb);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({w, a});
            m_cnt = a + 32'd4;
        end else if (load_start) begin
            m_cnt = load_base;
        end
        new_o = push && ob;
        new_r = push && rb;
        cap   = (new_o || new_r) && (err_clr || (!m_eo && !m_er));
        if (err_clr) begin
            m_eo = 0;
            m_er = 0;
        end
        if (new_o) m_eo = 1;
        if (new_r) m_er = 1;
        if (cap) m_ea = a;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        #2;
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.out_instr", out_instr, 32'd0);
        check_eq("rst.out_addr", out_addr, 32'd0);
        check_eq("rst.err_opcode", {31'd0, err_opcode}, 32'd0);
        check_eq("rst.err_range", {31'd0, err_range}, 32'd0);
        check_eq("rst.err_addr", err_addr, 32'd0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        check_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1;
        out_ready = 0;
        set_idle();
        model_clear();
        #1 rst_n = 0;
        @(posedge clk);
        #1;
        do_reset();

        // ADDI x1, x0, 5
        out_ready = 0;
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle("addi");
        in_valid = 0;
        check_eq("addi.instr", out_instr, 32'h00500093);
        check_eq("addi.addr", out_addr, 32'h0);
        out_ready = 1;
        cycle("addi_drain");

        // BEQ x1, x2, -8
        set_bundle(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        cycle("beq");
        in_valid = 0;
        check_eq("beq.instr", out_instr, 32'hFE208CE3);
        cycle("beq_drain");

        // LUI then address reload
        set_bundle(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        cycle("lui");
        check_eq("lui.instr", out_instr, 32'h123452B7);
        load_start = 1;
        load_base  = 32'h100;
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
        cycle("load");
        load_start = 0;
        check_eq("load.addr0", out_addr, 32'h100);
        cycle("load_next");
        check_eq("load.addr1", out_addr, 32'h104);
        in_valid = 0;
        cycle("load_drain");

        // Reset with two words buffered
        out_ready = 0;
        set_bundle(7'b0110011, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
        cycle("fill0");
        cycle("fill1");
        in_valid = 0;
        check_eq("fill.out_valid", {31'd0, out_valid}, 32'd1);
        do_reset();

        // Backpressure: three bundles, two slots
        out_ready = 0;
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        cycle("bp_a");
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
        cycle("bp_b");
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd1);
        check_eq("bp.full", {31'd0, in_ready}, 32'd0);
        cycle("bp_c_blocked");
        check_eq("bp.still_full", {31'd0, in_ready}, 32'd0);
        check_eq("bp.w0_instr", out_instr, 32'h00100093);
        check_eq("bp.w0_addr", out_addr, 32'h0);
        out_ready = 1;
        cycle("bp_rel0");
        check_eq("bp.w1_instr", out_instr, 32'h00100113);
        check_eq("bp.w1_addr", out_addr, 32'h4);
        cycle("bp_rel1");
        check_eq("bp.w2_instr", out_instr, 32'h00100193);
        check_eq("bp.w2_addr", out_addr, 32'h8);
        in_valid = 0;
        cycle("bp_drain");

        // Range and opcode errors
        err_clr    = 1;
        load_start = 1;
        load_base  = 32'h0;
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        cycle("rng");
        err_clr    = 0;
        load_start = 0;
        check_eq("rng.instr", out_instr, 32'h80000093);
`ifdef ENC_RANGE_CHECK_EN
        check_eq("rng.err_range", {31'd0, err_range}, 32'd1);
        check_eq("rng.err_addr", err_addr, 32'h0);
`else
        check_eq("rng.err_range", {31'd0, err_range}, 32'd0);
`endif
        set_bundle(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        cycle("badop");
        in_valid = 0;
        check_eq("badop.instr", out_instr, 32'h00000013);
        check_eq("badop.err_opcode", {31'd0, err_opcode}, 32'd1);
        err_clr = 1;
        cycle("clr");
        err_clr = 0;
        check_eq("clr.err_opcode", {31'd0, err_opcode}, 32'd0);
        cycle("clr_idle");

        // Counter wrap
        load_start = 1;
        load_base  = 32'hFFFFFFFC;
        set_bundle(7'b0010111, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000);
        cycle("wrap0");
        load_start = 0;
        cycle("wrap1");
        in_valid = 0;
        check_eq("wrap.addr", out_addr, 32'h0);
        cycle("wrap_drain");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [6:0]  op;
            logic [31:0] imm;
            int          m;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : c_ops[$urandom_range(0, 8)];
            m  = $urandom_range(0, 4);
            case (m)
                0: imm = 32'($urandom_range(0, 31));
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                3: imm = $urandom & 32'hFFFFF000;
                default: imm = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            set_bundle(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                       5'($urandom), imm);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            load_start = ($urandom_range(0, 15) == 0);
            load_base  = $urandom & 32'hFFFFFFFC;
            err_clr    = ($urandom_range(0, 15) == 0);
            cycle("rnd");
        end

        set_idle();
        out_ready = 1;
        for (int i = 0; i < 4; i++) cycle("tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  input field bundle valid.
REQ-004 in_ready  out  1  encoder can accept a bundle this cycle.
REQ-005 in_opcode  in  7  RV32I opcode; in_func3 in 3; in_func7 in 7; in_rd, in_rs1, in_rs2 in 5 each.
REQ-006 in_imm  in  32  immediate as a sign-extended value (U-type: value already shifted, low 12 bits zero).
REQ-007 load_start  in  1  pulse; loads the address counter from load_base.
REQ-008 load_base  in  32  start address for load_start (word aligned).
REQ-009 out_valid  out  1  encoded word available; out_ready in 1 consumer accepts.
REQ-010 out_instr  out  32  encoded instruction word; out_addr out 32 its IMEM byte address.
REQ-011 err_opcode  out  1  sticky: unsupported opcode seen; err_range out 1 sticky: immediate not representable.
REQ-012 err_addr  out  32  address of the first bundle that set any sticky error; err_clr in 1 clears the sticky errors.

Function
REQ-013 Handshake: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-014 Output buffering: a 2-entry FIFO holds {instr, addr}; out_* are driven from the head register.
REQ-015 Latency: a bundle accepted at edge N appears on out_* after edge N when the FIFO was empty; there is no combinational path from in_* to out_*.
REQ-016 in_ready SHALL equal (fifo_count < 2); it is independent of out_ready in the same cycle.
REQ-017 Push and pop in the same cycle leave the count unchanged and preserve order; pop on empty and push on full cannot occur.
REQ-018 R-type (0110011): {func7, rs2, rs1, func3, rd, opcode}.
REQ-019 I-type 0010011/0000011/1100111: {imm[11:0], rs1, func3, rd, opcode}.
REQ-020 Shifts (0010011 with func3 001/101): {func7, imm[4:0], rs1, func3, rd, opcode}.
REQ-021 S-type (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-022 B-type (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
REQ-023 J-type (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 U-type (0110111/0010111): {imm[31:12], rd, opcode}.
REQ-025 Unsupported opcode: emit 32'h00000013 (NOP), set err_opcode.
REQ-026 Address counter: each accepted bundle takes the counter value as out_addr; the counter then advances by 4, wrapping from 32'hFFFFFFFC to 0.
REQ-027 If load_start coincides with an accept, the bundle takes load_base and the counter becomes load_base+4.
REQ-028 err_addr captures on the first error set while both sticky flags are clear.
REQ-029 If err_clr and a new error occur in the same cycle, the set takes priority and err_addr recaptures.

Reset
REQ-030 While rst_n is low: FIFO empty, out_valid=0, out_instr=0, out_addr=0, counter=0, err_opcode=0, err_range=0, err_addr=0.
REQ-031 in_ready=1 one cycle after reset release.
REQ-032 Reset asserted mid-operation discards buffered words immediately (asynchronously).

Configuration
REQ-033 Macro ENC_RANGE_CHECK_EN controls immediate range checking.
REQ-034 Checks with ENC_RANGE_CHECK_EN defined:
- I/S: imm[31:11] uniform.
- shift: imm[31:5]=0.
- B: imm[0]=0 and imm[31:12] uniform.
- J: imm[0]=0 and imm[31:20] uniform.
- U: imm[11:0]=0.
- Any violation sets err_range; the truncated word is still emitted.
REQ-035 Without ENC_RANGE_CHECK_EN: no checks, err_range tied 0, encoding identical.

Verification
REQ-036 ADDI: opcode 0010011, rd=1, rs1=0, func3=0, imm=5, FIFO empty -> out_instr=32'h00500093, out_addr=0 one edge later.
REQ-037 BEQ: opcode 1100011, rs1=1, rs2=2, func3=0, imm=-8 -> out_instr=32'hFE208CE3.
REQ-038 LUI: rd=5, imm=32'h12345000 -> 32'h123452B7; then load_start with load_base=32'h100 plus accept -> out_addr=32'h100, next 32'h104.
REQ-039 Backpressure: out_ready=0, offer 3 bundles -> in_ready low after 2; release -> 3 words in order at addresses 0, 4, 8.
REQ-040 Range check: ADDI imm=2048 -> out_instr=32'h80000093; err_range=1 and err_addr=0 with ENC_RANGE_CHECK_EN, err_range=0 without; opcode 7'h7F -> 32'h00000013 and err_opcode=1.
REQ-041 Reset: rst_n low with 2 words buffered -> out_valid=0 before the next edge; counter restarts at 0.
